// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: takes one load or store from the MEM stage and sequences it onto the L1 D$
// opload/opstore channels. It runs the index valid/ready handshake, waits for operation_done,
// builds the store byte-lane mask and data, and aligns and extends load data. It holds
// mem_stall high while an operation is in flight.
// Ports:
//   clock, reset_n            clock; asynchronous active-low reset
//   req_*                     MEM-stage operation (valid, load/store, unsigned, one-hot size,
//                             address, LSB-aligned store data)
//   mem_stall                 combinational hold for MEM and upstream stages
//   resp_valid/err/rdata      one-cycle completion/error pulse; aligned load data
//   opload_*                  D$ load channel (index handshake, read data, done)
//   opstore_*                 D$ store channel (index handshake, mask/data, done)
module mem_access_ctrl #(
  parameter int unsigned IDX_W   = 19,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_is_load,
  input  logic             req_is_store,
  input  logic             req_is_unsigned,
  input  logic [3:0]       req_size,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  output logic             mem_stall,
  output logic             resp_valid,
  output logic [63:0]      resp_rdata,
  output logic             resp_err,
  output logic             opload_index_valid,
  output logic [IDX_W-1:0] opload_index,
  input  logic             opload_index_ready,
  input  logic [63:0]      opload_read_data,
  input  logic             opload_operation_done,
  output logic             opstore_index_valid,
  output logic [IDX_W-1:0] opstore_index,
  input  logic             opstore_index_ready,
  output logic [63:0]      opstore_write_mask,
  output logic [63:0]      opstore_write_data,
  input  logic             opstore_operation_done
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StLdReq, StLdWait, StStReq, StStWait, StDone} state_e;

  state_e r_state, w_state_next;

  // Operation latched at acceptance
  logic [2:0]       r_off;
  logic [3:0]       r_size;
  logic             r_uns;
  logic [CntW-1:0]  r_cnt, w_cnt_d;

  // Registered outputs and their next values
  logic             r_ld_valid, r_st_valid, r_resp_valid, r_resp_err;
  logic [IDX_W-1:0] r_ld_idx, r_st_idx;
  logic [63:0]      r_st_mask, r_st_data, r_rdata;
  logic             w_ld_valid_d, w_st_valid_d, w_resp_valid_d, w_resp_err_d;
  logic [IDX_W-1:0] w_ld_idx_d, w_st_idx_d;
  logic [63:0]      w_st_mask_d, w_st_data_d, w_rdata_d;

  // Request decode
  logic             w_is_mem, w_accept, w_size_ok, w_misalign, w_req_err;
  logic [2:0]       w_off;
  logic [3:0]       w_bytes;
  logic [7:0]       w_bmask, w_st_bmask;
  logic [63:0]      w_lsb_mask, w_st_mask, w_st_data;
  logic [IDX_W-1:0] w_idx;
  logic             unused_addr;

  // Completion / timeout
  logic             w_in_wait, w_ld_done, w_st_done, w_wait_done, w_tmo, w_err_next;
  logic [63:0]      w_ld_shift, w_ld_data;

  assign w_is_mem    = req_is_load | req_is_store;
  assign w_accept    = (r_state == StIdle) & req_valid & w_is_mem;
  assign w_off       = req_addr[2:0];
  assign w_idx       = req_addr[IDX_W+2:3];
  assign unused_addr = ^req_addr[63:IDX_W+3];

  always_comb begin
    w_size_ok = 1'b1;
    w_bytes   = 4'd0;
    w_bmask   = 8'h00;
    unique case (req_size)
      4'b0001: begin w_bytes = 4'd1; w_bmask = 8'h01; end
      4'b0010: begin w_bytes = 4'd2; w_bmask = 8'h03; end
      4'b0100: begin w_bytes = 4'd4; w_bmask = 8'h0F; end
      4'b1000: begin w_bytes = 4'd8; w_bmask = 8'hFF; end
      default: w_size_ok = 1'b0;  // non-one-hot size is treated as illegal
    endcase
  end

  assign w_misalign = (({1'b0, w_off} + w_bytes) > 4'd8);
  assign w_req_err  = (req_is_load & req_is_store) | ~w_size_ok | w_misalign;

  // Expand byte enables to bit masks: LSB-aligned for data trimming, shifted for the lane
  assign w_st_bmask = w_bmask << w_off;
  always_comb begin
    w_lsb_mask = '0;
    w_st_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      w_lsb_mask[8*i +: 8] = {8{w_bmask[i]}};
      w_st_mask[8*i +: 8]  = {8{w_st_bmask[i]}};
    end
  end
  assign w_st_data = (req_wdata & w_lsb_mask) << {w_off, 3'b000};

  // Load alignment and extension use the latched offset/size
  assign w_ld_shift = opload_read_data >> {r_off, 3'b000};
  always_comb begin
    unique case (r_size)
      4'b0001: w_ld_data = {{56{~r_uns & w_ld_shift[7]}},  w_ld_shift[7:0]};
      4'b0010: w_ld_data = {{48{~r_uns & w_ld_shift[15]}}, w_ld_shift[15:0]};
      4'b0100: w_ld_data = {{32{~r_uns & w_ld_shift[31]}}, w_ld_shift[31:0]};
      default: w_ld_data = w_ld_shift;
    endcase
  end

  // done is honoured only in WAIT, or in REQ when it coincides with the accepted handshake
  assign w_ld_done = opload_operation_done &
                     (((r_state == StLdReq) & opload_index_ready) | (r_state == StLdWait));
  assign w_st_done = opstore_operation_done &
                     (((r_state == StStReq) & opstore_index_ready) | (r_state == StStWait));
  assign w_in_wait   = (r_state == StLdWait) | (r_state == StStWait);
  assign w_wait_done = ((r_state == StLdWait) & opload_operation_done) |
                       ((r_state == StStWait) & opstore_operation_done);
  assign w_tmo       = (TIMEOUT != 0) && (r_cnt == CntW'(TIMEOUT - 1));
  assign w_err_next  = (w_accept & w_req_err) | (w_in_wait & ~w_wait_done & w_tmo);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_req_err)        w_state_next = StDone;
          else if (req_is_load) w_state_next = StLdReq;
          else                  w_state_next = StStReq;
        end
      end
      StLdReq:  if (opload_index_ready) w_state_next = opload_operation_done ? StDone : StLdWait;
      StLdWait: if (opload_operation_done | w_tmo) w_state_next = StDone;
      StStReq:  if (opstore_index_ready) w_state_next = opstore_operation_done ? StDone : StStWait;
      StStWait: if (opstore_operation_done | w_tmo) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_ld_valid_d   = (w_state_next == StLdReq);
    w_st_valid_d   = (w_state_next == StStReq);
    w_ld_idx_d     = '0;
    w_st_idx_d     = '0;
    w_st_mask_d    = '0;
    w_st_data_d    = '0;
    if (w_state_next == StLdReq) w_ld_idx_d = w_accept ? w_idx : r_ld_idx;
    if (w_state_next == StStReq) begin
      w_st_idx_d  = w_accept ? w_idx     : r_st_idx;
      w_st_mask_d = w_accept ? w_st_mask : r_st_mask;
      w_st_data_d = w_accept ? w_st_data : r_st_data;
    end
    w_resp_valid_d = (w_state_next == StDone) & ~w_err_next;
    w_resp_err_d   = (w_state_next == StDone) & w_err_next;
    w_rdata_d      = w_ld_done ? w_ld_data : r_rdata;
    w_cnt_d        = (w_in_wait && (w_state_next == r_state)) ? r_cnt + CntW'(1) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_off        <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_cnt        <= '0;
      r_ld_valid   <= 1'b0;
      r_st_valid   <= 1'b0;
      r_ld_idx     <= '0;
      r_st_idx     <= '0;
      r_st_mask    <= '0;
      r_st_data    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (w_accept) begin
        r_off  <= w_off;
        r_size <= req_size;
        r_uns  <= req_is_unsigned;
      end
      r_cnt        <= w_cnt_d;
      r_ld_valid   <= w_ld_valid_d;
      r_st_valid   <= w_st_valid_d;
      r_ld_idx     <= w_ld_idx_d;
      r_st_idx     <= w_st_idx_d;
      r_st_mask    <= w_st_mask_d;
      r_st_data    <= w_st_data_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_err   <= w_resp_err_d;
      r_rdata      <= w_rdata_d;
    end
  end

  assign mem_stall = (r_state == StLdReq) | (r_state == StLdWait) | (r_state == StStReq) |
                     (r_state == StStWait) | w_accept;

  assign resp_valid          = r_resp_valid;
  assign resp_err            = r_resp_err;
  assign resp_rdata          = r_rdata;
  assign opload_index_valid  = r_ld_valid;
  assign opload_index        = r_ld_idx;
  assign opstore_index_valid = r_st_valid;
  assign opstore_index       = r_st_idx;
  assign opstore_write_mask  = r_st_mask;
  assign opstore_write_data  = r_st_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl with hand-written multi-cycle sequences.
module tb_mem_access_ctrl;

  localparam int unsigned IdxW = 19;

  logic            clock, reset_n;
  logic            req_valid, req_is_load, req_is_store, req_is_unsigned;
  logic [3:0]      req_size;
  logic [63:0]     req_addr, req_wdata;
  logic            mem_stall, resp_valid, resp_err;
  logic [63:0]     resp_rdata;
  logic            opload_index_valid, opload_index_ready, opload_operation_done;
  logic [IdxW-1:0] opload_index;
  logic [63:0]     opload_read_data;
  logic            opstore_index_valid, opstore_index_ready, opstore_operation_done;
  logic [IdxW-1:0] opstore_index;
  logic [63:0]     opstore_write_mask, opstore_write_data;

  int n_total = 0;
  int n_bad   = 0;

  mem_access_ctrl #(.IDX_W(IdxW), .TIMEOUT(8)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .req_valid             (req_valid),
    .req_is_load           (req_is_load),
    .req_is_store          (req_is_store),
    .req_is_unsigned       (req_is_unsigned),
    .req_size              (req_size),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .mem_stall             (mem_stall),
    .resp_valid            (resp_valid),
    .resp_rdata            (resp_rdata),
    .resp_err              (resp_err),
    .opload_index_valid    (opload_index_valid),
    .opload_index          (opload_index),
    .opload_index_ready    (opload_index_ready),
    .opload_read_data      (opload_read_data),
    .opload_operation_done (opload_operation_done),
    .opstore_index_valid   (opstore_index_valid),
    .opstore_index         (opstore_index),
    .opstore_index_ready   (opstore_index_ready),
    .opstore_write_mask    (opstore_write_mask),
    .opstore_write_data    (opstore_write_data),
    .opstore_operation_done(opstore_operation_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        ld, st, uns;
    logic [3:0]  size;
    logic [63:0] addr, wdata, rdata;
    logic        err;
    logic [63:0] idx, mask, data, rexp;
  } vec_t;

  function automatic vec_t mk(input string name, input logic ld, input logic st,
                              input logic uns, input logic [3:0] size, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] rdata,
                              input logic err, input logic [63:0] idx, input logic [63:0] mask,
                              input logic [63:0] data, input logic [63:0] rexp);
    vec_t v;
    v.name = name; v.ld = ld; v.st = st; v.uns = uns; v.size = size; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.err = err; v.idx = idx; v.mask = mask;
    v.data = data; v.rexp = rexp;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; D$ ready and done are both high, so legal ops take the
  // minimum-latency path.
  task automatic run_vec(input vec_t v);
    req_valid = 1'b1; req_is_load = v.ld; req_is_store = v.st; req_is_unsigned = v.uns;
    req_size = v.size; req_addr = v.addr; req_wdata = v.wdata; opload_read_data = v.rdata;
    opload_index_ready = 1'b1; opload_operation_done = 1'b1;
    opstore_index_ready = 1'b1; opstore_operation_done = 1'b1;
    #1 check({v.name, ".stall_acc"}, 64'(mem_stall), 64'd1);
    @(negedge clock);
    req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    #1;
    if (v.err) begin
      check({v.name, ".err"},      64'(resp_err),            64'd1);
      check({v.name, ".rvalid"},   64'(resp_valid),          64'd0);
      check({v.name, ".ldvalid"},  64'(opload_index_valid),  64'd0);
      check({v.name, ".stvalid"},  64'(opstore_index_valid), 64'd0);
      check({v.name, ".stall"},    64'(mem_stall),           64'd0);
    end else begin
      check({v.name, ".stall_req"}, 64'(mem_stall),  64'd1);
      check({v.name, ".rvalid0"},   64'(resp_valid), 64'd0);
      if (v.ld) begin
        check({v.name, ".ldvalid"}, 64'(opload_index_valid),  64'd1);
        check({v.name, ".ldidx"},   64'(opload_index),        v.idx);
        check({v.name, ".stvalid"}, 64'(opstore_index_valid), 64'd0);
      end else begin
        check({v.name, ".stvalid"}, 64'(opstore_index_valid), 64'd1);
        check({v.name, ".stidx"},   64'(opstore_index),       v.idx);
        check({v.name, ".mask"},    opstore_write_mask,       v.mask);
        check({v.name, ".data"},    opstore_write_data,       v.data);
        check({v.name, ".ldvalid"}, 64'(opload_index_valid),  64'd0);
      end
      @(negedge clock); #1;
      check({v.name, ".rvalid"},   64'(resp_valid), 64'd1);
      check({v.name, ".err0"},     64'(resp_err),   64'd0);
      check({v.name, ".stall_dn"}, 64'(mem_stall),  64'd0);
      if (v.ld) check({v.name, ".rdata"}, resp_rdata, v.rexp);
    end
    @(negedge clock); #1;
    check({v.name, ".rvalid_end"}, 64'(resp_valid), 64'd0);
    check({v.name, ".err_end"},    64'(resp_err),   64'd0);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = mk("sd",   0, 1, 0, 4'b1000, 64'h28,   64'h1122334455667788, 64'h0, 0,
                  64'h5,   64'hFFFFFFFFFFFFFFFF, 64'h1122334455667788, 64'h0);
    vecs[1]  = mk("sb",   0, 1, 0, 4'b0001, 64'h1005, 64'hAB, 64'h0, 0,
                  64'h200, 64'h0000FF0000000000, 64'h0000AB0000000000, 64'h0);
    vecs[2]  = mk("sh",   0, 1, 0, 4'b0010, 64'h2,    64'hFFFFFFFFFFFF1234, 64'h0, 0,
                  64'h0,   64'h00000000FFFF0000, 64'h0000000012340000, 64'h0);
    vecs[3]  = mk("sw",   0, 1, 0, 4'b0100, 64'h4C,   64'hDEADBEEFCAFEF00D, 64'h0, 0,
                  64'h9,   64'hFFFFFFFF00000000, 64'hCAFEF00D00000000, 64'h0);
    vecs[4]  = mk("lh",   1, 0, 0, 4'b0010, 64'h1006, 64'h0, 64'h8001000000000000, 0,
                  64'h200, 64'h0, 64'h0, 64'hFFFFFFFFFFFF8001);
    vecs[5]  = mk("lhu",  1, 0, 1, 4'b0010, 64'h1006, 64'h0, 64'h8001000000000000, 0,
                  64'h200, 64'h0, 64'h0, 64'h0000000000008001);
    vecs[6]  = mk("lb",   1, 0, 0, 4'b0001, 64'h3,    64'h0, 64'h00000000F0000000, 0,
                  64'h0,   64'h0, 64'h0, 64'hFFFFFFFFFFFFFFF0);
    vecs[7]  = mk("lwu",  1, 0, 1, 4'b0100, 64'h44,   64'h0, 64'h89ABCDEF01234567, 0,
                  64'h8,   64'h0, 64'h0, 64'h0000000089ABCDEF);
    vecs[8]  = mk("lw",   1, 0, 0, 4'b0100, 64'h44,   64'h0, 64'h89ABCDEF01234567, 0,
                  64'h8,   64'h0, 64'h0, 64'hFFFFFFFF89ABCDEF);
    vecs[9]  = mk("ld",   1, 0, 0, 4'b1000, 64'h10,   64'h0, 64'h0123456789ABCDEF, 0,
                  64'h2,   64'h0, 64'h0, 64'h0123456789ABCDEF);
    vecs[10] = mk("lw_mis", 1, 0, 0, 4'b0100, 64'h6, 64'h0, 64'h0, 1,
                  64'h0, 64'h0, 64'h0, 64'h0);
    vecs[11] = mk("sd_mis", 0, 1, 0, 4'b1000, 64'h9, 64'h0, 64'h0, 1,
                  64'h0, 64'h0, 64'h0, 64'h0);
    vecs[12] = mk("ldst_ill", 1, 1, 0, 4'b0001, 64'h0, 64'h0, 64'h0, 1,
                  64'h0, 64'h0, 64'h0, 64'h0);
    vecs[13] = mk("lb_edge", 1, 0, 0, 4'b0001, 64'h7, 64'h0, 64'h7F00000000000000, 0,
                  64'h0, 64'h0, 64'h0, 64'h000000000000007F);

    reset_n = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_is_unsigned = 1'b0; req_size = 4'b0; req_addr = '0; req_wdata = '0;
    opload_index_ready = 1'b0; opload_read_data = '0; opload_operation_done = 1'b0;
    opstore_index_ready = 1'b0; opstore_operation_done = 1'b0;

    // Reset state
    #3;
    check("rst.stall",   64'(mem_stall),           64'd0);
    check("rst.rvalid",  64'(resp_valid),          64'd0);
    check("rst.err",     64'(resp_err),            64'd0);
    check("rst.rdata",   resp_rdata,               64'd0);
    check("rst.ldvalid", 64'(opload_index_valid),  64'd0);
    check("rst.stvalid", 64'(opstore_index_valid), 64'd0);
    check("rst.mask",    opstore_write_mask,       64'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock); #1;

    // Non-memory request: ignored
    req_valid = 1'b1;
    #1 check("nonmem.stall", 64'(mem_stall), 64'd0);
    @(negedge clock); req_valid = 1'b0; #1;
    check("nonmem.ldvalid", 64'(opload_index_valid),  64'd0);
    check("nonmem.stvalid", 64'(opstore_index_valid), 64'd0);
    check("nonmem.rvalid",  64'(resp_valid),          64'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Ready held low 5 cycles, then no done: timeout after 8 WAIT cycles
    opload_index_ready = 1'b0; opload_operation_done = 1'b0;
    opstore_index_ready = 1'b0; opstore_operation_done = 1'b0;
    req_valid = 1'b1; req_is_load = 1'b1; req_size = 4'b1000; req_addr = 64'h18;
    #1 check("tmo.stall_acc", 64'(mem_stall), 64'd1);
    @(negedge clock); req_valid = 1'b0; req_is_load = 1'b0; req_addr = 64'hFFF8;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("tmo.hold_valid", 64'(opload_index_valid), 64'd1);
      check("tmo.hold_stall", 64'(mem_stall),          64'd1);
      check("tmo.hold_idx",   64'(opload_index),       64'h3);
      if (i == 4) opload_index_ready = 1'b1;
      @(negedge clock);
    end
    opload_index_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("tmo.wait_valid", 64'(opload_index_valid), 64'd0);
      check("tmo.wait_stall", 64'(mem_stall),          64'd1);
      check("tmo.wait_err",   64'(resp_err),           64'd0);
      @(negedge clock);
    end
    #1;
    check("tmo.err",    64'(resp_err),   64'd1);
    check("tmo.rvalid", 64'(resp_valid), 64'd0);
    check("tmo.stall",  64'(mem_stall),  64'd0);
    @(negedge clock); #1;
    check("tmo.err_end", 64'(resp_err), 64'd0);

    // Store whose done arrives later in WAIT
    opstore_index_ready = 1'b1;
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 4'b0100; req_addr = 64'h8;
    req_wdata = 64'h12345678AABBCCDD;
    @(negedge clock); req_valid = 1'b0; req_is_store = 1'b0; #1;
    check("stw.valid", 64'(opstore_index_valid), 64'd1);
    check("stw.idx",   64'(opstore_index),       64'h1);
    check("stw.mask",  opstore_write_mask,       64'h00000000FFFFFFFF);
    check("stw.data",  opstore_write_data,       64'h00000000AABBCCDD);
    @(negedge clock); #1;
    check("stw.wait_valid", 64'(opstore_index_valid), 64'd0);
    check("stw.wait_stall", 64'(mem_stall),           64'd1);
    check("stw.wait_rv",    64'(resp_valid),          64'd0);
    opstore_operation_done = 1'b1;
    @(negedge clock); opstore_operation_done = 1'b0; #1;
    check("stw.rvalid", 64'(resp_valid), 64'd1);
    @(negedge clock); #1;
    check("stw.rvalid_end", 64'(resp_valid), 64'd0);

    // Reset during LD_WAIT, late done ignored, next load normal
    opload_index_ready = 1'b1;
    req_valid = 1'b1; req_is_load = 1'b1; req_size = 4'b1000; req_addr = 64'h20;
    @(negedge clock); req_valid = 1'b0; req_is_load = 1'b0;
    @(negedge clock); #1;
    check("rmid.in_wait", 64'(mem_stall), 64'd1);
    reset_n = 1'b0; #1;
    check("rmid.stall",   64'(mem_stall),          64'd0);
    check("rmid.ldvalid", 64'(opload_index_valid), 64'd0);
    check("rmid.rdata",   resp_rdata,              64'd0);
    check("rmid.rvalid",  64'(resp_valid),         64'd0);
    @(negedge clock); reset_n = 1'b1;
    opload_operation_done = 1'b1; opload_read_data = 64'hDEADDEADDEADDEAD;
    @(negedge clock); opload_operation_done = 1'b0; #1;
    check("rmid.late_rv",    64'(resp_valid), 64'd0);
    check("rmid.late_rdata", resp_rdata,      64'd0);
    check("rmid.late_stall", 64'(mem_stall),  64'd0);
    @(negedge clock); #1;
    run_vec(mk("ld_after_rst", 1, 0, 0, 4'b1000, 64'h20, 64'h0, 64'hCAFEBABE12345678, 0,
               64'h4, 64'h0, 64'h0, 64'hCAFEBABE12345678));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
